// File: rtl/tag_ram_ctrl.sv
// Controller for the synchronous-read MSI tag RAM. It serialises lookup/update requests,
// waits out the one-cycle RAM read latency, and returns hit/victim information as a single-cycle pulse.
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [AWIDTH+TWIDTH-1:0] req_addr,
  input  logic [1:0]               req_state,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [1:0]               rsp_state,
  output logic [TWIDTH-1:0]        rsp_tag,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [TWIDTH+1:0]        ram_din,
  output logic                     ram_we,
  input  logic [TWIDTH+1:0]        ram_dout
);

  localparam int DWIDTH = TWIDTH + 2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WR, S_RESP} state_e;

  state_e              state_q;
  logic                op_q;
  logic [TWIDTH-1:0]   tag_q;
  logic [1:0]          wstate_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_hit_q;
  logic [1:0]          rsp_state_q;
  logic [TWIDTH-1:0]   rsp_tag_q;
  logic [AWIDTH-1:0]   ram_addr_q;
  logic [DWIDTH-1:0]   ram_din_q;
  logic                ram_we_q;

  logic                hit_d;
  logic [1:0]          rsp_state_d;
  logic [TWIDTH-1:0]   rsp_tag_d;
  logic [DWIDTH-1:0]   ram_din_d;

  // The reserved encoding 11 is folded onto Invalid wherever a state is reported or written.
  function automatic logic [1:0] msi_clean(input logic [1:0] s);
    return (s == 2'b11) ? 2'b00 : s;
  endfunction

  function automatic logic tag_hit(input logic [DWIDTH-1:0] e, input logic [TWIDTH-1:0] t);
    logic [1:0] s;
    s = e[DWIDTH-1:DWIDTH-2];
    return ((s == 2'b01) || (s == 2'b10)) && (e[TWIDTH-1:0] == t);
  endfunction

  always_comb begin
    hit_d       = tag_hit(ram_dout, tag_q);
    rsp_state_d = msi_clean(ram_dout[DWIDTH-1:DWIDTH-2]);
    rsp_tag_d   = ram_dout[TWIDTH-1:0];
    ram_din_d   = {msi_clean(wstate_q), tag_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      tag_q       <= '0;
      wstate_q    <= 2'b00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_state_q <= 2'b00;
      rsp_tag_q   <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            tag_q       <= req_addr[AWIDTH +: TWIDTH];
            wstate_q    <= req_state;
            ram_addr_q  <= req_addr[AWIDTH-1:0];
            req_ready_q <= 1'b0;
            state_q     <= S_RD;
          end
        end
        S_RD: state_q <= S_CMP;
        // RAM read data is valid here; the pre-write entry becomes the response.
        S_CMP: begin
          rsp_hit_q   <= hit_d;
          rsp_state_q <= rsp_state_d;
          rsp_tag_q   <= rsp_tag_d;
          if (op_q) begin
            ram_din_q <= ram_din_d;
            ram_we_q  <= 1'b1;
            state_q   <= S_WR;
          end else begin
            state_q   <= S_RESP;
          end
        end
        S_WR: begin
          ram_we_q <= 1'b0;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_state = rsp_state_q;
  assign rsp_tag   = rsp_tag_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule
